// File: rtl/truth_table_sweeper.sv
// rtl/truth_table_sweeper.sv - exhaustive truth-table sweeper for a small combinational block
module truth_table_sweeper #(
    parameter int N_IN   = 2,
    parameter int SETTLE = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [(1<<N_IN)-1:0]   exp_mask,
    input  logic                   dut_s,
    output logic [N_IN-1:0]        dut_in,
    output logic                   busy,
    output logic                   done,
    output logic [(1<<N_IN)-1:0]   table_out,
    output logic [(1<<N_IN)-1:0]   mismatch,
    output logic                   pass
);

    localparam int M  = 1 << N_IN;
    // Settle counter is sized for the full 0..15 legal range of SETTLE.
    localparam int CW = 4;
    localparam logic [CW-1:0]   RELOAD = (SETTLE > 0) ? CW'(SETTLE - 1) : '0;
    localparam logic [N_IN-1:0] LAST   = N_IN'(M - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_SAMPLE,
        S_DONE
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [CW-1:0]   count;
    logic [M-1:0]    mask;
    logic [M-1:0]    table_upd;
    logic [M-1:0]    mismatch_upd;
    logic            last;

    // State register; reset aborts any sweep in progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: WAIT is skipped entirely when SETTLE is zero.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = (SETTLE > 0) ? S_WAIT : S_SAMPLE;
                end
            end
            S_WAIT: begin
                if (count == '0) begin
                    state_next = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                if (last) begin
                    state_next = S_DONE;
                end else begin
                    state_next = (SETTLE > 0) ? S_WAIT : S_SAMPLE;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Tables as they will look after the current minterm is recorded, so
    // pass can be computed from the final mismatch in the same edge.
    always_comb begin
        table_upd            = table_out;
        mismatch_upd         = mismatch;
        table_upd[dut_in]    = dut_s;
        mismatch_upd[dut_in] = dut_s ^ mask[dut_in];
        last                 = (dut_in == LAST);
    end

    // Datapath: minterm stepping, settle timing, sampling and result flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            dut_in    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            table_out <= '0;
            mismatch  <= '0;
            pass      <= 1'b0;
            count     <= '0;
            mask      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        mask      <= exp_mask;
                        table_out <= '0;
                        mismatch  <= '0;
                        pass      <= 1'b0;
                        dut_in    <= '0;
                        busy      <= 1'b1;
                        count     <= RELOAD;
                    end
                end
                S_WAIT: begin
                    if (count != '0) begin
                        count <= count - CW'(1);
                    end
                end
                S_SAMPLE: begin
                    table_out <= table_upd;
                    mismatch  <= mismatch_upd;
                    if (last) begin
                        busy <= 1'b0;
                        done <= 1'b1;
                        pass <= (mismatch_upd == '0);
                    end else begin
                        dut_in <= dut_in + N_IN'(1);
                        count  <= RELOAD;
                    end
                end
                S_DONE: begin
                    done <= 1'b0;
                end
                default: begin
                    done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb/tb_truth_table_sweeper.sv - scoreboard bench for truth_table_sweeper
module tb_truth_table_sweeper;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // u0: N_IN=2 SETTLE=1, gate selectable good (a|~b) or faulty (a&~b)
    logic       start0, s0, faulty0, busy0, done0, pass0;
    logic [3:0] mask0, tbl0, mis0;
    logic [1:0] in0;
    // u1: N_IN=2 SETTLE=0, good gate
    logic       start1, s1, busy1, done1, pass1;
    logic [3:0] mask1, tbl1, mis1;
    logic [1:0] in1;
    // u2: N_IN=3 SETTLE=2, majority gate
    logic       start2, s2, busy2, done2, pass2;
    logic [7:0] mask2, tbl2, mis2;
    logic [2:0] in2;

    assign s0 = faulty0 ? (in0[1] & ~in0[0]) : (in0[1] | ~in0[0]);
    assign s1 = in1[1] | ~in1[0];
    assign s2 = (in2[2] & in2[1]) | (in2[2] & in2[0]) | (in2[1] & in2[0]);

    truth_table_sweeper #(.N_IN(2), .SETTLE(1)) u0 (
        .clk(clk), .reset(reset), .start(start0), .exp_mask(mask0), .dut_s(s0),
        .dut_in(in0), .busy(busy0), .done(done0), .table_out(tbl0),
        .mismatch(mis0), .pass(pass0)
    );
    truth_table_sweeper #(.N_IN(2), .SETTLE(0)) u1 (
        .clk(clk), .reset(reset), .start(start1), .exp_mask(mask1), .dut_s(s1),
        .dut_in(in1), .busy(busy1), .done(done1), .table_out(tbl1),
        .mismatch(mis1), .pass(pass1)
    );
    truth_table_sweeper #(.N_IN(3), .SETTLE(2)) u2 (
        .clk(clk), .reset(reset), .start(start2), .exp_mask(mask2), .dut_s(s2),
        .dut_in(in2), .busy(busy2), .done(done2), .table_out(tbl2),
        .mismatch(mis2), .pass(pass2)
    );

    typedef struct {
        logic [7:0] tbl;
        logic [7:0] mis;
        logic       pss;
        int         lat;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    // kind 0: a|~b, 1: a&~b (2 inputs), 2: majority (3 inputs)
    function automatic logic [7:0] model_tbl(input int kind);
        logic [7:0] t;
        logic [2:0] m;
        t = '0;
        for (int i = 0; i < 8; i++) begin
            m = 3'(i);
            case (kind)
                0: if (i < 4) t[i] = m[1] | ~m[0];
                1: if (i < 4) t[i] = m[1] & ~m[0];
                default: t[i] = (m[2] & m[1]) | (m[2] & m[0]) | (m[1] & m[0]);
            endcase
        end
        return t;
    endfunction

    function automatic exp_t make_exp(input int kind, input logic [7:0] msk, input int lat);
        exp_t e;
        e.tbl = model_tbl(kind);
        e.mis = e.tbl ^ msk;
        e.pss = (e.mis == 8'd0);
        e.lat = lat;
        return e;
    endfunction

    // Waits (from the negedge after the start edge) for done on u0; -1 on timeout.
    task automatic wait_done0(input int budget, output int k);
        k = 0;
        while (done0 !== 1'b1 && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (done0 !== 1'b1) k = -1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_vec++;
        if ({busy0, done0, pass0, in0, tbl0, mis0} !== 13'd0) begin
            n_err++;
            $display("FAIL reset_u0: got busy=%b done=%b pass=%b in=%b tbl=%b mis=%b, want all 0",
                     busy0, done0, pass0, in0, tbl0, mis0);
        end
        n_vec++;
        if ({busy2, done2, pass2, in2, tbl2, mis2} !== 22'd0) begin
            n_err++;
            $display("FAIL reset_u2: got busy=%b done=%b pass=%b in=%b tbl=%b mis=%b, want all 0",
                     busy2, done2, pass2, in2, tbl2, mis2);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_good_sweep();
        exp_t e;
        int   k;
        bit   seen;
        faulty0 = 1'b0;
        mask0   = 4'b1101;
        sb.push_back(make_exp(0, {4'd0, mask0}, 8));
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        k = 0;
        seen = 0;
        while (!seen && k <= 40) begin
            if (done0 === 1'b1) begin
                seen = 1;
            end else begin
                n_vec++;
                if (busy0 !== 1'b1 || in0 !== 2'(k / 2)) begin
                    n_err++;
                    $display("FAIL good_step k=%0d: got busy=%b in=%0d, want busy=1 in=%0d",
                             k, busy0, in0, k / 2);
                end
                @(negedge clk);
                k++;
            end
        end
        n_vec++;
        if (!seen || sb.size() == 0) begin
            n_err++;
            $display("FAIL good_done: done not seen within budget (k=%0d)", k);
        end else begin
            e = sb.pop_front();
            n_vec++;
            if (k != e.lat || busy0 !== 1'b0) begin
                n_err++;
                $display("FAIL good_latency: got %0d busy=%b, want %0d busy=0", k, busy0, e.lat);
            end
            n_vec++;
            if ({4'd0, tbl0} !== e.tbl || {4'd0, mis0} !== e.mis || pass0 !== e.pss) begin
                n_err++;
                $display("FAIL good_result: got tbl=%b mis=%b pass=%b, want tbl=%b mis=%b pass=%b",
                         tbl0, mis0, pass0, e.tbl[3:0], e.mis[3:0], e.pss);
            end
        end
        @(negedge clk);
        n_vec++;
        if (done0 !== 1'b0 || in0 !== 2'd3 || pass0 !== 1'b1) begin
            n_err++;
            $display("FAIL good_after: got done=%b in=%0d pass=%b, want done=0 in=3 pass=1",
                     done0, in0, pass0);
        end
    endtask

    task automatic test_faulty_dut();
        exp_t e;
        int   k;
        faulty0 = 1'b1;
        mask0   = 4'b1101;
        sb.push_back(make_exp(1, {4'd0, mask0}, 8));
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        wait_done0(40, k);
        e = sb.pop_front();
        n_vec++;
        if (k != e.lat) begin
            n_err++;
            $display("FAIL faulty_latency: got %0d, want %0d", k, e.lat);
        end
        n_vec++;
        if ({4'd0, tbl0} !== e.tbl || {4'd0, mis0} !== e.mis || pass0 !== e.pss) begin
            n_err++;
            $display("FAIL faulty_result: got tbl=%b mis=%b pass=%b, want tbl=%b mis=%b pass=%b",
                     tbl0, mis0, pass0, e.tbl[3:0], e.mis[3:0], e.pss);
        end
        faulty0 = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_start_ignored();
        exp_t e;
        int   k;
        int   extra;
        mask0 = 4'b1101;
        sb.push_back(make_exp(0, {4'd0, mask0}, 8));
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        k = 0;
        while (done0 !== 1'b1 && k < 40) begin
            if (k == 3) start0 = 1'b1;
            if (k == 4) begin
                start0 = 1'b0;
                mask0  = 4'b0000;
            end
            if (k == 5) start0 = 1'b1;
            if (k == 6) start0 = 1'b0;
            @(negedge clk);
            k++;
        end
        e = sb.pop_front();
        n_vec++;
        if (k != e.lat) begin
            n_err++;
            $display("FAIL noise_latency: got %0d, want %0d", k, e.lat);
        end
        n_vec++;
        if ({4'd0, mis0} !== e.mis || pass0 !== e.pss) begin
            n_err++;
            $display("FAIL noise_result: got mis=%b pass=%b, want mis=%b pass=%b",
                     mis0, pass0, e.mis[3:0], e.pss);
        end
        extra = 0;
        repeat (12) begin
            @(negedge clk);
            if (done0 === 1'b1 || busy0 === 1'b1) extra++;
        end
        n_vec++;
        if (extra != 0) begin
            n_err++;
            $display("FAIL noise_single_done: got %0d extra busy/done cycles, want 0", extra);
        end
        mask0 = 4'b1101;
    endtask

    task automatic test_reset_mid_sweep();
        exp_t e;
        int   k;
        int   extra;
        mask0 = 4'b1101;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_vec++;
        if (busy0 !== 1'b0 || in0 !== 2'd0 || tbl0 !== 4'd0 || pass0 !== 1'b0 || done0 !== 1'b0) begin
            n_err++;
            $display("FAIL midreset_state: got busy=%b in=%0d tbl=%b pass=%b done=%b, want all 0",
                     busy0, in0, tbl0, pass0, done0);
        end
        extra = 0;
        repeat (12) begin
            @(negedge clk);
            if (done0 === 1'b1) extra++;
        end
        n_vec++;
        if (extra != 0) begin
            n_err++;
            $display("FAIL midreset_no_done: got %0d done cycles, want 0", extra);
        end
        sb.push_back(make_exp(0, {4'd0, mask0}, 8));
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        wait_done0(40, k);
        e = sb.pop_front();
        n_vec++;
        if (k != e.lat || {4'd0, tbl0} !== e.tbl || pass0 !== e.pss) begin
            n_err++;
            $display("FAIL midreset_fresh: got k=%0d tbl=%b pass=%b, want k=%0d tbl=%b pass=%b",
                     k, tbl0, pass0, e.lat, e.tbl[3:0], e.pss);
        end
        @(negedge clk);
    endtask

    task automatic test_settle_zero();
        exp_t e;
        int   k;
        mask1 = 4'b1101;
        sb.push_back(make_exp(0, {4'd0, mask1}, 4));
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        k = 0;
        while (done1 !== 1'b1 && k < 20) begin
            n_vec++;
            if (in1 !== 2'(k) || busy1 !== 1'b1) begin
                n_err++;
                $display("FAIL s0_step k=%0d: got in=%0d busy=%b, want in=%0d busy=1",
                         k, in1, busy1, k);
            end
            @(negedge clk);
            k++;
        end
        e = sb.pop_front();
        n_vec++;
        if (k != e.lat || {4'd0, tbl1} !== e.tbl || {4'd0, mis1} !== e.mis || pass1 !== e.pss) begin
            n_err++;
            $display("FAIL s0_result: got k=%0d tbl=%b mis=%b pass=%b, want k=%0d tbl=%b mis=%b pass=%b",
                     k, tbl1, mis1, pass1, e.lat, e.tbl[3:0], e.mis[3:0], e.pss);
        end
        @(negedge clk);
    endtask

    task automatic test_three_inputs();
        exp_t e;
        int   k;
        mask2 = 8'b11101000;
        sb.push_back(make_exp(2, mask2, 24));
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        k = 0;
        while (done2 !== 1'b1 && k < 60) begin
            n_vec++;
            if (in2 !== 3'(k / 3)) begin
                n_err++;
                $display("FAIL n3_step k=%0d: got in=%0d, want %0d", k, in2, k / 3);
            end
            @(negedge clk);
            k++;
        end
        e = sb.pop_front();
        n_vec++;
        if (k != e.lat || tbl2 !== e.tbl || mis2 !== e.mis || pass2 !== e.pss) begin
            n_err++;
            $display("FAIL n3_result: got k=%0d tbl=%b mis=%b pass=%b, want k=%0d tbl=%b mis=%b pass=%b",
                     k, tbl2, mis2, pass2, e.lat, e.tbl, e.mis, e.pss);
        end
        @(negedge clk);
    endtask

    initial begin
        reset   = 1'b1;
        start0  = 1'b0;
        start1  = 1'b0;
        start2  = 1'b0;
        faulty0 = 1'b0;
        mask0   = 4'b1101;
        mask1   = 4'b1101;
        mask2   = 8'b11101000;
        test_reset();
        test_good_sweep();
        test_faulty_dut();
        test_start_ignored();
        test_reset_mid_sweep();
        test_settle_zero();
        test_three_inputs();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
